ingress_framing_fifo: RTL and testbench

// - Upstream stage of ethernetsniffer: sits between the MAC-side Avalon-ST source and the sniffer's stream input.
// - Buffers 32-bit packet beats in a show-ahead FIFO and honours backpressure on both sides.
// - Sanitises framing so the comparators and controller only ever see well-formed sop...eop packets:
//   - drops stray beats that arrive outside a packet;
//   - force-terminates truncated packets and flags them.

---
 rtl/ingress_framing_fifo.sv | 122 ++++++++++++
 tb/tb_ingress_framing_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_framing_fifo.sv
// Ingress framing FIFO: hold register plus show-ahead FIFO that repairs sop/eop framing.
// Define INGRESS_STATS_EN to add the pkt/drop/trunc saturating counters.
module ingress_framing_fifo #(
  parameter int DEPTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_empty,
  input  logic [5:0]  in_error,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [1:0]  out_empty,
  output logic [5:0]  out_error,
  output logic        out_valid,
  input  logic        out_ready
`ifdef INGRESS_STATS_EN
  ,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [15:0] trunc_count
`endif
);

  typedef struct packed {
    logic [5:0]  error;
    logic [1:0]  empty;
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } beat_t;

  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  beat_t                mem [DEPTH];
  beat_t                hold_b, in_b, wr_b, rd_b;
  logic                 hold_valid, in_pkt;
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic                 pop, space, accept, stray, load, trunc, commit;

  assign in_b = '{error: in_error, empty: in_empty, eop: in_eop, sop: in_sop, data: in_data};

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop this cycle frees a slot, so out_ready feeds in_ready combinationally.
  assign space     = (count < FULL_CNT) | pop;
  assign in_ready  = !hold_valid | space;
  assign accept    = in_valid & in_ready;
  assign stray     = accept & !in_pkt & !in_sop;
  assign load      = accept & !stray;
  assign trunc     = accept & in_pkt & in_sop;
  // A non-eop beat stays in hold until its successor arrives to decide its eop.
  assign commit    = hold_valid & space & (hold_b.eop | accept);

  always_comb begin
    wr_b = hold_b;
    if (trunc) begin
      wr_b.eop      = 1'b1;
      wr_b.empty    = '0;
      wr_b.error[5] = 1'b1;
    end
  end

  assign rd_b      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = rd_b.data;
  assign out_sop   = rd_b.sop;
  assign out_eop   = rd_b.eop;
  assign out_empty = rd_b.empty;
  assign out_error = rd_b.error;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_b     <= '0;
      hold_valid <= 1'b0;
      in_pkt     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (load) begin
        hold_b     <= in_b;
        hold_valid <= 1'b1;
        in_pkt     <= !in_eop;
      end else if (commit) begin
        hold_valid <= 1'b0;
      end
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({commit, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wr_ptr] <= wr_b;
  end

`ifdef INGRESS_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_count   <= '0;
      drop_count  <= '0;
      trunc_count <= '0;
    end else begin
      if (pop && out_eop && pkt_count != '1) pkt_count <= pkt_count + 1'b1;
      if (stray && drop_count != '1)         drop_count <= drop_count + 1'b1;
      if (trunc && trunc_count != '1)        trunc_count <= trunc_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ingress_framing_fifo.sv
// Directed bench for ingress_framing_fifo; counter checks compile in with INGRESS_STATS_EN.
module tb_ingress_framing_fifo;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic [5:0]  in_error = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sop, out_eop;
  logic [1:0]  out_empty;
  logic [5:0]  out_error;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef INGRESS_STATS_EN
  logic [31:0] pkt_count, drop_count;
  logic [15:0] trunc_count;
`endif

  ingress_framing_fifo #(.DEPTH(16), .ADDR_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .in_error(in_error), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready)
`ifdef INGRESS_STATS_EN
    , .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        sop, eop;
    logic [1:0]  empty;
    logic [5:0]  error;
    int          cyc;
  } cap_t;

  cap_t cap_q[$];
  int   cyc = 0;
  int   total = 0, bad = 0, stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (n_rst && out_valid && out_ready)
      cap_q.push_back('{out_data, out_sop, out_eop, out_empty, out_error, cyc});

  task automatic apply_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    cap_q.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] em, input logic [5:0] er);
    int w = 0;
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_error = er; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      w++; stalls++;
      @(negedge clk);
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout data=%h in_ready=%b required 1", d, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    in_valid = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    total++;
    if ({out_data, out_sop, out_eop, out_empty, out_error} !== 42'd0) begin
      bad++; $display("FAIL reset_gate out_data=%h sop=%b eop=%b required all 0", out_data, out_sop, out_eop);
    end
`ifdef INGRESS_STATS_EN
    total++;
    if (pkt_count !== 0 || drop_count !== 0 || trunc_count !== 0) begin
      bad++; $display("FAIL reset_cnt pkt=%0d drop=%0d trunc=%0d required 0", pkt_count, drop_count, trunc_count);
    end
`endif
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    send(32'hA, 1, 0, 0, 0);
    send(32'hB, 0, 0, 0, 0);
    send(32'hC, 0, 1, 2, 0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || out_eop !== 1'b0) begin
      bad++; $display("FAIL basic_lat1 valid=%b data=%h eop=%b required 1/B/0", out_valid, out_data, out_eop);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hC || out_eop !== 1'b1 || out_empty !== 2'd2) begin
      bad++; $display("FAIL basic_lat2 valid=%b data=%h eop=%b empty=%0d required 1/C/1/2",
                      out_valid, out_data, out_eop, out_empty);
    end
    repeat (3) @(negedge clk);
    total++;
    if (cap_q.size() != 3) begin
      bad++; $display("FAIL basic_size got=%0d required 3", cap_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cap_q[i].data !== 32'hA + i || cap_q[i].sop !== (i == 0) || cap_q[i].eop !== (i == 2) ||
            cap_q[i].empty !== (i == 2 ? 2'd2 : 2'd0)) begin
          bad++; $display("FAIL basic_beat%0d data=%h sop=%b eop=%b empty=%0d", i,
                          cap_q[i].data, cap_q[i].sop, cap_q[i].eop, cap_q[i].empty);
        end
      end
    end
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      bad++; $display("FAIL basic_idle valid=%b data=%h required 0/0", out_valid, out_data);
    end
`ifdef INGRESS_STATS_EN
    total++;
    if (pkt_count !== 32'd1) begin
      bad++; $display("FAIL basic_pkt got=%0d required 1", pkt_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(32'd100 + i, i == 0, 0, 0, 0);
    in_data = 32'd117; in_sop = 0; in_eop = 0; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_full in_ready=%b required 0", in_ready);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd100 || out_sop !== 1'b1) begin
      bad++; $display("FAIL bp_head valid=%b data=%0d sop=%b required 1/100/1", out_valid, out_data, out_sop);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 17; i < 20; i++) send(32'd100 + i, 0, i == 19, 0, 0);
    repeat (25) @(negedge clk);
    total++;
    if (cap_q.size() != 20) begin
      bad++; $display("FAIL bp_size got=%0d required 20", cap_q.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        total++;
        if (cap_q[i].data !== 32'd100 + i || cap_q[i].sop !== (i == 0) || cap_q[i].eop !== (i == 19)) begin
          bad++; $display("FAIL bp_beat%0d data=%0d sop=%b eop=%b required %0d", i,
                          cap_q[i].data, cap_q[i].sop, cap_q[i].eop, 100 + i);
        end
      end
    end
  endtask

  task automatic test_stray();
    apply_reset();
    send(32'h301, 0, 0, 0, 0);
    send(32'h302, 0, 1, 0, 0);
    send(32'h3AA, 1, 1, 1, 0);
    repeat (5) @(negedge clk);
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL stray_size got=%0d required 1", cap_q.size());
    end else begin
      total++;
      if (cap_q[0].data !== 32'h3AA || !cap_q[0].sop || !cap_q[0].eop || cap_q[0].empty !== 2'd1) begin
        bad++; $display("FAIL stray_beat data=%h sop=%b eop=%b empty=%0d required 3aa/1/1/1",
                        cap_q[0].data, cap_q[0].sop, cap_q[0].eop, cap_q[0].empty);
      end
    end
`ifdef INGRESS_STATS_EN
    total++;
    if (drop_count !== 32'd2 || pkt_count !== 32'd1) begin
      bad++; $display("FAIL stray_cnt drop=%0d pkt=%0d required 2/1", drop_count, pkt_count);
    end
`endif
  endtask

  task automatic test_truncate();
    logic [31:0] xd [4];
    logic [3:0]  xs, xe;
    logic [5:0]  xr [4];
    xd[0] = 32'h401; xd[1] = 32'h402; xd[2] = 32'h404; xd[3] = 32'h405;
    xs = 4'b0101; xe = 4'b1010;
    xr[0] = 6'h00; xr[1] = 6'h23; xr[2] = 6'h00; xr[3] = 6'h00;
    apply_reset();
    send(32'h401, 1, 0, 0, 0);
    send(32'h402, 0, 0, 1, 6'h03);
    send(32'h404, 1, 0, 0, 0);
    send(32'h405, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    total++;
    if (cap_q.size() != 4) begin
      bad++; $display("FAIL trunc_size got=%0d required 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_q[i].data !== xd[i] || cap_q[i].sop !== xs[i] || cap_q[i].eop !== xe[i] ||
            cap_q[i].empty !== 2'd0 || cap_q[i].error !== xr[i]) begin
          bad++; $display("FAIL trunc_beat%0d data=%h sop=%b eop=%b empty=%0d err=%h required %h/%b/%b/0/%h",
                          i, cap_q[i].data, cap_q[i].sop, cap_q[i].eop, cap_q[i].empty, cap_q[i].error,
                          xd[i], xs[i], xe[i], xr[i]);
        end
      end
    end
`ifdef INGRESS_STATS_EN
    total++;
    if (trunc_count !== 16'd1 || pkt_count !== 32'd2) begin
      bad++; $display("FAIL trunc_cnt trunc=%0d pkt=%0d required 1/2", trunc_count, pkt_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int s0;
    apply_reset();
    s0 = stalls;
    for (int i = 0; i < 8; i++) send(32'h500 + i, 1, 1, 0, 0);
    repeat (5) @(negedge clk);
    total++;
    if (stalls != s0) begin
      bad++; $display("FAIL b2b_ready stalls=%0d required 0", stalls - s0);
    end
    total++;
    if (cap_q.size() != 8) begin
      bad++; $display("FAIL b2b_size got=%0d required 8", cap_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (cap_q[i].data !== 32'h500 + i || cap_q[i].cyc != cap_q[0].cyc + i) begin
          bad++; $display("FAIL b2b_beat%0d data=%h cyc_off=%0d required %h/%0d", i,
                          cap_q[i].data, cap_q[i].cyc - cap_q[0].cyc, 32'h500 + i, i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send(32'h601, 1, 0, 0, 0);
    send(32'h602, 0, 0, 0, 0);
    send(32'h603, 0, 0, 0, 0);
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
      bad++; $display("FAIL rstmid_state valid=%b in_ready=%b data=%h required 0/1/0", out_valid, in_ready, out_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    cap_q.delete();
    send(32'h604, 0, 0, 0, 0);
    send(32'h605, 0, 0, 0, 0);
    send(32'h606, 0, 1, 0, 0);
    repeat (5) @(negedge clk);
    total++;
    if (cap_q.size() != 0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_out size=%0d valid=%b required 0/0", cap_q.size(), out_valid);
    end
`ifdef INGRESS_STATS_EN
    total++;
    if (drop_count !== 32'd3) begin
      bad++; $display("FAIL rstmid_drop got=%0d required 3", drop_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stray();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
